// File: rtl/canvas_stroke_writer_if.sv
// rtl/canvas_stroke_writer_if.sv - canvas block-memory write port (wea/addra/dina)
interface canvas_stroke_writer_if;
    logic        wea;
    logic [16:0] addra;
    logic [1:0]  dina;

    modport master (output wea, output addra, output dina);
    modport slave  (input  wea, input  addra, input  dina);
endinterface

// File: rtl/canvas_stroke_writer.sv
// rtl/canvas_stroke_writer.sv - brush stamp / canvas clear writer for the 320x240x2b canvas
// Optional macro CANVAS_ERASE_EN adds MOUSE_RIGHT, which stamps BG instead of INK.
module canvas_stroke_writer #(
    parameter int unsigned BRUSH_R = 1,
    parameter logic [1:0]  INK     = 2'd1,
    parameter logic [1:0]  BG      = 2'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] mouse_x,
    input  logic [9:0] mouse_y,
    input  logic       MOUSE_LEFT,
`ifdef CANVAS_ERASE_EN
    input  logic       MOUSE_RIGHT,
`endif
    input  logic       clear_req,
    output logic       busy,
    output logic       clear_done,
    canvas_stroke_writer_if.master mem
);

    localparam logic signed [3:0] R_S       = 4'(BRUSH_R);
    localparam logic [16:0]       LAST_ADDR = 17'd76799;

    typedef enum logic [1:0] {IDLE, STAMP, CLEAR} state_t;

    state_t            state;
    logic              clear_pend;
    logic              clear_last;
    logic              pen_prev;
    logic              last_valid;
    logic [8:0]        cx, cy;
    logic [8:0]        last_cx, last_cy;
    logic signed [3:0] dx, dy;
    logic [1:0]        stamp_val;
    logic [16:0]       clr_addr;

    // Screen coordinates are at twice the canvas resolution
    logic [8:0] cur_cx, cur_cy;
    logic       unused_lsb;
    assign cur_cx     = mouse_x[9:1];
    assign cur_cy     = mouse_y[9:1];
    assign unused_lsb = mouse_x[0] ^ mouse_y[0];

    logic       pen;
    logic [1:0] pen_val;
`ifdef CANVAS_ERASE_EN
    assign pen     = MOUSE_LEFT | MOUSE_RIGHT;
    assign pen_val = MOUSE_LEFT ? INK : BG;
`else
    assign pen     = MOUSE_LEFT;
    assign pen_val = INK;
`endif

    logic moved, trigger;
    assign moved   = !last_valid || (cur_cx != last_cx) || (cur_cy != last_cy);
    assign trigger = pen && (!pen_prev || moved);

    logic signed [10:0] px, py;
    logic               in_range;
    logic [16:0]        pix_addr;
    logic               last_off;
    assign px       = $signed({2'b00, cx}) + $signed({{7{dx[3]}}, dx});
    assign py       = $signed({2'b00, cy}) + $signed({{7{dy[3]}}, dy});
    assign in_range = !px[10] && !py[10] && (px < 11'sd320) && (py < 11'sd240);
    assign pix_addr = 17'(py) * 17'd320 + 17'(px);
    assign last_off = (dx == R_S) && (dy == R_S);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            clear_done <= 1'b0;
            clear_last <= 1'b0;
            clear_pend <= 1'b0;
            pen_prev   <= 1'b0;
            last_valid <= 1'b0;
            cx         <= '0;
            cy         <= '0;
            last_cx    <= '0;
            last_cy    <= '0;
            dx         <= '0;
            dy         <= '0;
            stamp_val  <= '0;
            clr_addr   <= '0;
            mem.wea    <= 1'b0;
            mem.addra  <= '0;
            mem.dina   <= '0;
        end else begin
            clear_done <= clear_last;
            clear_last <= 1'b0;
            if (clear_req) clear_pend <= 1'b1;

            case (state)
                IDLE: begin
                    busy     <= 1'b0;
                    mem.wea  <= 1'b0;
                    pen_prev <= pen;
                    if (clear_pend) begin
                        // A request arriving on the entry cycle still counts
                        state      <= CLEAR;
                        clear_pend <= clear_req;
                        clr_addr   <= '0;
                    end else if (trigger) begin
                        state      <= STAMP;
                        cx         <= cur_cx;
                        cy         <= cur_cy;
                        last_cx    <= cur_cx;
                        last_cy    <= cur_cy;
                        last_valid <= 1'b1;
                        dx         <= -R_S;
                        dy         <= -R_S;
                        stamp_val  <= pen_val;
                    end
                end
                STAMP: begin
                    busy      <= 1'b1;
                    mem.wea   <= in_range;
                    mem.addra <= in_range ? pix_addr : '0;
                    mem.dina  <= stamp_val;
                    if (last_off) begin
                        state <= IDLE;
                    end else if (dx == R_S) begin
                        dx <= -R_S;
                        dy <= dy + 4'sd1;
                    end else begin
                        dx <= dx + 4'sd1;
                    end
                end
                CLEAR: begin
                    busy      <= 1'b1;
                    mem.wea   <= 1'b1;
                    mem.addra <= clr_addr;
                    mem.dina  <= BG;
                    if (clr_addr == LAST_ADDR) begin
                        state      <= IDLE;
                        clear_last <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 17'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_canvas_stroke_writer.sv
// tb/tb_canvas_stroke_writer.sv - scoreboard bench for canvas_stroke_writer
module tb_canvas_stroke_writer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] mouse_x, mouse_y;
    logic       mouse_left, mouse_right, clear_req;
    logic       busy, clear_done;

    canvas_stroke_writer_if mem_if ();

    canvas_stroke_writer #(.BRUSH_R(1), .INK(2'd1), .BG(2'd0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mouse_x    (mouse_x),
        .mouse_y    (mouse_y),
        .MOUSE_LEFT (mouse_left),
`ifdef CANVAS_ERASE_EN
        .MOUSE_RIGHT(mouse_right),
`endif
        .clear_req  (clear_req),
        .busy       (busy),
        .clear_done (clear_done),
        .mem        (mem_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] addr;
        logic [1:0]  data;
    } wr_t;

    typedef struct {
        int x;
        int y;
        int n_wr;
        int first;
    } vec_t;

    wr_t  exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   wr_count = 0;
    int   busy_cycles = 0;
    int   cd_count = 0;
    int   first_addr = 0;
    logic prev_last_write = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            wr_t e;
            if (busy) busy_cycles++;
            if (mem_if.wea) begin
                wr_count++;
                if (wr_count == 1) first_addr = int'(mem_if.addra);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(mem_if.addra), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_if.addra), 32'(e.addr));
                    check("wr_data", 32'(mem_if.dina), 32'(e.data));
                end
            end
            if (clear_done) begin
                cd_count++;
                check("clear_done_after_last_write", 32'(prev_last_write), 32'd1);
            end
            prev_last_write = mem_if.wea && (mem_if.addra == 17'd76799);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_cnt();
        wr_count    = 0;
        busy_cycles = 0;
        cd_count    = 0;
        first_addr  = -1;
    endtask

    task automatic push_stamp(input int x, input int y, input logic [1:0] v);
        int cx, cy, px, py;
        cx = x / 2;
        cy = y / 2;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                px = cx + dx;
                py = cy + dy;
                if (px >= 0 && px < 320 && py >= 0 && py < 240)
                    exp_q.push_back('{addr: 17'(py * 320 + px), data: v});
            end
        end
    endtask

    task automatic push_clear();
        for (int a = 0; a < 76800; a++) exp_q.push_back('{addr: 17'(a), data: 2'd0});
    endtask

    task automatic wait_busy(input logic level, input int bound, input string name);
        int n = 0;
        while (busy !== level && n < bound) begin
            step();
            n++;
        end
        check(name, 32'(busy), 32'(level));
    endtask

    task automatic release_buttons();
        mouse_left  = 1'b0;
        mouse_right = 1'b0;
        repeat (3) step();
    endtask

    task automatic run_stamp(input string name, input int x, input int y, input logic l,
                             input logic r, input logic [1:0] ink, input int n_wr, input int first);
        clr_cnt();
        push_stamp(x, y, ink);
        mouse_x     = 10'(x);
        mouse_y     = 10'(y);
        mouse_left  = l;
        mouse_right = r;
        wait_busy(1'b1, 10, {name, "_busy_rise"});
        wait_busy(1'b0, 30, {name, "_busy_fall"});
        check({name, "_busy_cycles"}, 32'(busy_cycles), 32'd9);
        check({name, "_writes"}, 32'(wr_count), 32'(n_wr));
        check({name, "_first_addr"}, 32'(first_addr), 32'(first));
        check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int n;
        vecs[0] = '{x: 100, y: 60,  n_wr: 9, first: 9329};
        vecs[1] = '{x: 0,   y: 0,   n_wr: 4, first: 0};
        vecs[2] = '{x: 639, y: 479, n_wr: 4, first: 76478};
        vecs[3] = '{x: 638, y: 0,   n_wr: 4, first: 318};
        vecs[4] = '{x: 0,   y: 479, n_wr: 4, first: 76160};
        vecs[5] = '{x: 200, y: 100, n_wr: 9, first: 15779};

        rst_n       = 1'b0;
        mouse_x     = '0;
        mouse_y     = '0;
        mouse_left  = 1'b0;
        mouse_right = 1'b0;
        clear_req   = 1'b0;
        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wea", 32'(mem_if.wea), 32'd0);
        check("rst_addra", 32'(mem_if.addra), 32'd0);
        check("rst_dina", 32'(mem_if.dina), 32'd0);
        check("rst_clear_done", 32'(clear_done), 32'd0);
        rst_n = 1'b1;
        clr_cnt();
        repeat (5) step();
        check("idle_no_writes", 32'(wr_count), 32'd0);

        // Reset in the middle of a clear aborts at once
        clr_cnt();
        push_clear();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        n = 0;
        while (wr_count < 50 && n < 100) begin
            step();
            n++;
        end
        check("midclear_progress", 32'(wr_count >= 50), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_wea", 32'(mem_if.wea), 32'd0);
        check("abort_addra", 32'(mem_if.addra), 32'd0);
        check("abort_dina", 32'(mem_if.dina), 32'd0);
        check("abort_clear_done", 32'(clear_done), 32'd0);
        exp_q.delete();
        repeat (3) step();
        rst_n = 1'b1;
        clr_cnt();
        repeat (20) step();
        check("after_abort_writes", 32'(wr_count), 32'd0);
        check("after_abort_busy", 32'(busy_cycles), 32'd0);

        foreach (vecs[i]) begin
            release_buttons();
            run_stamp($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, 1'b1, 1'b0, 2'd1,
                      vecs[i].n_wr, vecs[i].first);
        end

        // Holding still must not restamp; moving one canvas pixel must
        release_buttons();
        run_stamp("hold_press", 100, 60, 1'b1, 1'b0, 2'd1, 9, 9329);
        clr_cnt();
        repeat (200) step();
        check("hold_no_writes", 32'(wr_count), 32'd0);
        check("hold_no_busy", 32'(busy_cycles), 32'd0);
        run_stamp("move", 102, 60, 1'b1, 1'b0, 2'd1, 9, 9330);

`ifdef CANVAS_ERASE_EN
        release_buttons();
        run_stamp("erase", 100, 60, 1'b0, 1'b1, 2'd0, 9, 9329);
        release_buttons();
        run_stamp("both", 100, 60, 1'b1, 1'b1, 2'd1, 9, 9329);
`endif

        // Clear requested mid-stamp: stamp completes, then one full clear
        release_buttons();
        clr_cnt();
        push_stamp(100, 60, 2'd1);
        push_clear();
        mouse_x    = 10'd100;
        mouse_y    = 10'd60;
        mouse_left = 1'b1;
        repeat (3) step();
        clear_req = 1'b1;
        step();
        clear_req  = 1'b0;
        mouse_left = 1'b0;
        n = 0;
        while (cd_count == 0 && n < 80000) begin
            step();
            n++;
        end
        check("clear_done_seen", 32'(cd_count > 0), 32'd1);
        check("clear_done_busy_low", 32'(busy), 32'd0);
        repeat (5) step();
        check("clear_done_pulses", 32'(cd_count), 32'd1);
        check("stamp_clear_writes", 32'(wr_count), 32'd76809);
        check("stamp_clear_busy", 32'(busy_cycles), 32'd76809);
        check("stamp_clear_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/canvas_stroke_writer.md
# canvas_stroke_writer

Write-side companion to the VGA pixel generators: turns mouse activity into writes on the 320x240, 2-bit-per-pixel canvas block memory that the display path reads at half resolution. It stamps a square brush around the mouse position while the left button is held, and it sweeps the whole canvas to background on a clear request. It drives the memory's write port (wea/addra/dina); the VGA read port is untouched.

## Interface
- BRUSH_R, 1, brush half-width in canvas pixels; stamp is (2*BRUSH_R+1)^2 pixels, legal range 0..7
- INK, 2'd1, value written for a stroke pixel
- BG, 2'd0, value written by clear (and by erase, when compiled in)
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- mouse_x  input  10  mouse column, screen pixels 0..639
- mouse_y  input  10  mouse row, screen pixels 0..479
- MOUSE_LEFT  input  1  left button level
- MOUSE_RIGHT  input  1  right button level (present only with CANVAS_ERASE_EN)
- clear_req  input  1  single-cycle clear request pulse
- busy  output  1  high whenever state is not IDLE
- clear_done  output  1  one-cycle pulse after the last clear write
- wea  output  1  memory write enable
- addra  output  17  memory address, y*320 + x
- dina  output  2  memory write data

## Operation
- Canvas coordinates: cx = mouse_x>>1, cy = mouse_y>>1 (computed at stamp start, latched).
- States: IDLE, STAMP, CLEAR.
- clear_req is latched into clear_pend in any state; cleared on entry to CLEAR.
- IDLE priority: clear_pend -> CLEAR; else MOUSE_LEFT and stamp trigger -> STAMP; else stay.
- Stamp trigger: button rising edge (MOUSE_LEFT high, was low last IDLE cycle) or latched (cx,cy) differs from last stamped (cx,cy). Holding still never restamps. last-position register is invalid after reset.
- STAMP: offsets dy outer, dx inner, each from -BRUSH_R to +BRUSH_R, one pixel per cycle. Pixel (cx+dx, cy+dy) computed in signed 11-bit; written only if 0<=x<320 and 0<=y<240, else the cycle issues wea=0 (clipped pixels still consume a cycle). After last offset -> IDLE.
- CLEAR: addresses 0..76799 ascending, one per cycle, dina=BG; after 76799 -> IDLE, clear_done pulses.
- Button release mid-stamp: stamp completes. clear_req mid-stamp: stamp completes, CLEAR follows directly via IDLE. clear_req during CLEAR: latched, causes a second full clear.
- Address arithmetic: addra = y*320 + x, max 76799; never exceeds 17 bits.

## Timing
- Reset values: busy=0, clear_done=0, wea=0, addra=0, dina=0, state IDLE, clear_pend=0, last-position invalid.
- wea/addra/dina/busy/clear_done are registered: first write appears the cycle after the IDLE->STAMP/CLEAR transition edge.
- Stamp duration exactly (2*BRUSH_R+1)^2 cycles of busy; clear exactly 76800 cycles.
- busy falls the cycle after the final write; at least one IDLE cycle between operations.
- wea=0 in IDLE. Reset asserted mid-operation aborts immediately; no partial restart.

## Configuration
- CANVAS_ERASE_EN defined: MOUSE_RIGHT port exists; in IDLE, MOUSE_RIGHT (with MOUSE_LEFT low) triggers a stamp writing BG instead of INK, same trigger and clipping rules; left beats right when both held.
- Undefined: no MOUSE_RIGHT port; all stamps write INK.

## Test plan
- Reset: rst_n low mid-clear -> all outputs 0 same cycle; after release, IDLE and no writes.
- Stamp, BRUSH_R=1: mouse (100,60), MOUSE_LEFT rises -> 9 writes, dina=1, addra 9329,9330,9331,9649,9650,9651,9969,9970,9971; busy high 9 cycles.
- Corner clip: mouse (0,0), left press -> 9 busy cycles, wea=1 only for addra 0,1,320,321.
- Hold still: keep left held at (100,60) 200 cycles after stamp -> no further writes; move to (102,60) -> one new stamp centered cx=51.
- Clear: clear_req pulse -> 76800 writes addra 0..76799 dina=0, clear_done one cycle after last write; clear_req during a stamp -> stamp finishes, then full clear.
- CANVAS_ERASE_EN: MOUSE_RIGHT press at (100,60) -> same 9 addresses with dina=0; both buttons -> dina=1.
